bus_snoop_capture: RTL and testbench

//  Debug-overlay source stage. Snoops the 68000 bus, captures one complete bus cycle
//  (address, data, function code, strobes) and publishes it as three 32-bit words
//  (val_a/val_d/val_s) that feed the on-screen hex debug overlay directly.

---
 rtl/bus_snoop_capture.sv | 206 ++++++++++++++++++++
 tb/tb_bus_snoop_capture.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_snoop_capture.sv
// bus_snoop_capture: snoops the 68000 bus, captures one complete bus cycle
// (address, data, function code, strobes, bus error) and publishes it as three
// 32-bit words for the hex debug overlay. Publication is rate-limited by a
// holdoff counter so the displayed values stay readable.
//
// Optional feature macro: DBG_BREAK_EN
//   defined   : address breakpoint; a matching cycle is always published and
//               raises halt, which blocks further publication until resume.
//   undefined : halt is tied low; brk_addr/brk_ena/resume are ignored.
module bus_snoop_capture #(
  parameter int HOLD_CYCLES = 3200000,
  parameter int CNT_W       = 22
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clken,
  input  logic [22:0] cpu_addr,
  input  logic [15:0] cpu_din,
  input  logic [15:0] cpu_dout,
  input  logic        cpu_as_n,
  input  logic        cpu_uds_n,
  input  logic        cpu_lds_n,
  input  logic        cpu_rw,
  input  logic [2:0]  cpu_fc,
  input  logic        dtack_n,
  input  logic        berr_n,
  input  logic        freeze,
  input  logic [23:0] brk_addr,
  input  logic        brk_ena,
  input  logic        resume,
  output logic [31:0] val_a,
  output logic [31:0] val_d,
  output logic [31:0] val_s,
  output logic        halt
);

  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_END  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              w_cap_addr;
  logic              w_cap_data;
  logic              w_done_set;

  // Shadow copy of the bus cycle in flight
  logic [22:0]       r_sh_addr;
  logic [2:0]        r_sh_fc;
  logic              r_sh_rw;
  logic              r_sh_uds_n;
  logic              r_sh_lds_n;
  logic [15:0]       r_sh_data;
  logic              r_sh_berr;

  logic              r_done;
  logic [CNT_W-1:0]  r_holdoff;
  logic              w_hold_zero;
  logic              w_pub;
  logic              w_hold_clr;
  logic              r_seq;
  logic [31:0]       r_val_a;
  logic [31:0]       r_val_d;
  logic [31:0]       r_val_s;

  // Capture FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Capture FSM next state and capture strobes; moves only on bus-phase enable
  always_comb begin
    w_state_next = r_state;
    w_cap_addr   = 1'b0;
    w_cap_data   = 1'b0;
    w_done_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (clken && !cpu_as_n) begin
          w_state_next = S_WAIT;
          w_cap_addr   = 1'b1;
        end
      end
      S_WAIT: begin
        if (clken) begin
          if (!dtack_n || !berr_n) begin
            w_state_next = S_END;
            w_cap_data   = 1'b1;
          end else if (cpu_as_n) begin
            // aborted cycle: shadow content is simply never published
            w_state_next = S_IDLE;
          end
        end
      end
      S_END: begin
        if (clken && cpu_as_n) begin
          w_state_next = S_IDLE;
          w_done_set   = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Shadow registers: address phase at WAIT entry, data phase at END entry
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh_addr  <= '0;
      r_sh_fc    <= '0;
      r_sh_rw    <= 1'b0;
      r_sh_uds_n <= 1'b0;
      r_sh_lds_n <= 1'b0;
      r_sh_data  <= '0;
      r_sh_berr  <= 1'b0;
    end else begin
      if (w_cap_addr) begin
        r_sh_addr  <= cpu_addr;
        r_sh_fc    <= cpu_fc;
        r_sh_rw    <= cpu_rw;
        r_sh_uds_n <= cpu_uds_n;
        r_sh_lds_n <= cpu_lds_n;
      end
      if (w_cap_data) begin
        r_sh_data <= r_sh_rw ? cpu_din : cpu_dout;
        r_sh_berr <= ~berr_n;
      end
    end
  end

  // One-clock completion pulse following the END->IDLE transition
  always_ff @(posedge clk) begin
    if (reset) r_done <= 1'b0;
    else       r_done <= w_done_set;
  end

  assign w_hold_zero = (r_holdoff == '0);

`ifdef DBG_BREAK_EN
  logic r_match;
  logic r_halt;
  logic w_pub_brk;
  logic w_unused;

  assign w_unused   = brk_addr[0];
  // A breakpoint hit wins over holdoff and freeze; resume in the same clock
  // as a new hit lets that hit through and keeps halt asserted.
  assign w_pub_brk  = r_done & r_match & (~r_halt | resume);
  assign w_pub      = w_pub_brk | (r_done & w_hold_zero & ~freeze & ~r_halt);
  assign w_hold_clr = resume;
  assign halt       = r_halt;

  // Breakpoint compare on the word address, evaluated at WAIT entry
  always_ff @(posedge clk) begin
    if (reset)           r_match <= 1'b0;
    else if (w_cap_addr) r_match <= brk_ena && (cpu_addr == brk_addr[23:1]);
  end

  // Halt request: set by a published breakpoint hit, cleared by resume
  always_ff @(posedge clk) begin
    if (reset)          r_halt <= 1'b0;
    else if (w_pub_brk) r_halt <= 1'b1;
    else if (resume)    r_halt <= 1'b0;
  end
`else
  logic w_unused;

  assign w_unused   = ^{brk_addr, brk_ena, resume};
  assign w_pub      = r_done & w_hold_zero & ~freeze;
  assign w_hold_clr = 1'b0;
  assign halt       = 1'b0;
`endif

  // Holdoff counter: reload on publish, otherwise count down to zero every clk
  always_ff @(posedge clk) begin
    if (reset)             r_holdoff <= '0;
    else if (w_pub)        r_holdoff <= HOLD_RELOAD;
    else if (w_hold_clr)   r_holdoff <= '0;
    else if (!w_hold_zero) r_holdoff <= r_holdoff - 1'b1;
  end

  // Published words; only a publish or reset changes them
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seq   <= 1'b0;
      r_val_a <= '0;
      r_val_d <= '0;
      r_val_s <= '0;
    end else if (w_pub) begin
      r_seq   <= ~r_seq;
      r_val_a <= {8'h00, r_sh_addr, 1'b0};
      r_val_d <= {16'h0000, r_sh_data};
      r_val_s <= {24'h000000, r_sh_fc, r_sh_rw, ~r_sh_uds_n, ~r_sh_lds_n,
                  r_sh_berr, ~r_seq};
    end
  end

  assign val_a = r_val_a;
  assign val_d = r_val_d;
  assign val_s = r_val_s;

endmodule

// File: tb/tb_bus_snoop_capture.sv
// Directed testbench for bus_snoop_capture with HOLD_CYCLES=4.
// Bus inputs are driven on the falling edge and outputs sampled on a falling
// edge, so each check sees the state after the preceding rising edge.
module tb_bus_snoop_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        clken;
  logic [22:0] cpu_addr;
  logic [15:0] cpu_din;
  logic [15:0] cpu_dout;
  logic        cpu_as_n;
  logic        cpu_uds_n;
  logic        cpu_lds_n;
  logic        cpu_rw;
  logic [2:0]  cpu_fc;
  logic        dtack_n;
  logic        berr_n;
  logic        freeze;
  logic [23:0] brk_addr;
  logic        brk_ena;
  logic        resume;
  logic [31:0] val_a;
  logic [31:0] val_d;
  logic [31:0] val_s;
  logic        halt;

  int n_vec = 0;
  int n_err = 0;

  bus_snoop_capture #(.HOLD_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .clken(clken),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .cpu_as_n(cpu_as_n), .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n),
    .cpu_rw(cpu_rw), .cpu_fc(cpu_fc), .dtack_n(dtack_n), .berr_n(berr_n),
    .freeze(freeze), .brk_addr(brk_addr), .brk_ena(brk_ena), .resume(resume),
    .val_a(val_a), .val_d(val_d), .val_s(val_s), .halt(halt)
  );

  always #5 clk = ~clk;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One complete bus cycle, called on a falling edge. Returns on the falling
  // edge after the END->IDLE edge; the publish edge is the next rising edge.
  task automatic bus_cycle(input logic [23:0] addr, input logic rw,
                           input logic [15:0] din, input logic [15:0] dout,
                           input logic [2:0] fc, input logic uds_n,
                           input logic lds_n, input logic ack, input logic err);
    cpu_addr  = addr[23:1];
    cpu_rw    = rw;
    cpu_din   = din;
    cpu_dout  = dout;
    cpu_fc    = fc;
    cpu_uds_n = uds_n;
    cpu_lds_n = lds_n;
    cpu_as_n  = 1'b0;
    @(negedge clk);
    dtack_n = ~ack;
    berr_n  = ~err;
    @(negedge clk);
    cpu_as_n = 1'b1;
    dtack_n  = 1'b1;
    berr_n   = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(3);
    n_vec++;
    if ({val_a, val_d, val_s} !== 96'h0) begin
      n_err++;
      $display("FAIL reset_vals: got %h want %h", {val_a, val_d, val_s}, 96'h0);
    end else $display("ok   reset_vals: %h", {val_a, val_d, val_s});
    n_vec++;
    if (halt !== 1'b0) begin
      n_err++;
      $display("FAIL reset_halt: got %b want 0", halt);
    end else $display("ok   reset_halt: %b", halt);
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_read;
    bus_cycle(24'hFC0030, 1'b1, 16'h4E71, 16'hAAAA, 3'd6, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    n_vec++;
    if ({val_a, val_d, val_s} !== 96'h00FC0030_00004E71_000000DD) begin
      n_err++;
      $display("FAIL read: got %h want %h", {val_a, val_d, val_s},
               96'h00FC0030_00004E71_000000DD);
    end else $display("ok   read: %h", {val_a, val_d, val_s});
  endtask

  // Three cycles back to back: the second completes while holdoff is 1 and
  // is dropped, the third sees holdoff at 0 and is published.
  task automatic test_back_to_back;
    idle(6);
    fork
      begin
        bus_cycle(24'h000420, 1'b0, 16'hBEEF, 16'h1234, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        bus_cycle(24'h001000, 1'b1, 16'h5555, 16'h0000, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        bus_cycle(24'h123456, 1'b1, 16'h0F0F, 16'h0000, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0);
      end
      begin
        repeat (4) @(negedge clk);
        n_vec++;
        if ({val_a, val_d, val_s} !== 96'h00000420_00001234_000000A4) begin
          n_err++;
          $display("FAIL b2b_first: got %h want %h", {val_a, val_d, val_s},
                   96'h00000420_00001234_000000A4);
        end else $display("ok   b2b_first: %h", {val_a, val_d, val_s});
        repeat (3) @(negedge clk);
        n_vec++;
        if ({val_a, val_d, val_s} !== 96'h00000420_00001234_000000A4) begin
          n_err++;
          $display("FAIL b2b_dropped: got %h want %h", {val_a, val_d, val_s},
                   96'h00000420_00001234_000000A4);
        end else $display("ok   b2b_dropped: %h", {val_a, val_d, val_s});
        repeat (3) @(negedge clk);
        n_vec++;
        if ({val_a, val_d, val_s} !== 96'h00123456_00000F0F_00000059) begin
          n_err++;
          $display("FAIL b2b_third: got %h want %h", {val_a, val_d, val_s},
                   96'h00123456_00000F0F_00000059);
        end else $display("ok   b2b_third: %h", {val_a, val_d, val_s});
      end
    join
  endtask

  task automatic test_abort;
    idle(6);
    cpu_addr  = 23'h2AAAAA;
    cpu_rw    = 1'b1;
    cpu_din   = 16'hDEAD;
    cpu_fc    = 3'd7;
    cpu_uds_n = 1'b0;
    cpu_lds_n = 1'b0;
    cpu_as_n  = 1'b0;
    @(negedge clk);
    cpu_as_n = 1'b1;
    idle(6);
    n_vec++;
    if ({val_a, val_d, val_s} !== 96'h00123456_00000F0F_00000059) begin
      n_err++;
      $display("FAIL abort: got %h want %h", {val_a, val_d, val_s},
               96'h00123456_00000F0F_00000059);
    end else $display("ok   abort: %h", {val_a, val_d, val_s});
  endtask

  task automatic test_clken;
    clken     = 1'b0;
    cpu_addr  = 23'h000300;
    cpu_rw    = 1'b1;
    cpu_din   = 16'h6666;
    cpu_as_n  = 1'b0;
    @(negedge clk);
    dtack_n = 1'b0;
    @(negedge clk);
    cpu_as_n = 1'b1;
    dtack_n  = 1'b1;
    idle(2);
    clken = 1'b1;
    idle(4);
    n_vec++;
    if ({val_a, val_d, val_s} !== 96'h00123456_00000F0F_00000059) begin
      n_err++;
      $display("FAIL clken_gate: got %h want %h", {val_a, val_d, val_s},
               96'h00123456_00000F0F_00000059);
    end else $display("ok   clken_gate: %h", {val_a, val_d, val_s});
  endtask

  task automatic test_freeze;
    logic [23:0] addrs [3];
    addrs[0] = 24'h000010;
    addrs[1] = 24'h0A0A0A;
    addrs[2] = 24'hFFFFFE;
    idle(6);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_cycle(addrs[i], 1'b1, 16'h1000 + 16'(i), 16'h0000, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(2);
      n_vec++;
      if ({val_a, val_d, val_s} !== 96'h00123456_00000F0F_00000059) begin
        n_err++;
        $display("FAIL freeze_hold%0d: got %h want %h", i, {val_a, val_d, val_s},
                 96'h00123456_00000F0F_00000059);
      end else $display("ok   freeze_hold%0d: %h", i, {val_a, val_d, val_s});
    end
    freeze = 1'b0;
    bus_cycle(24'hABCDEE, 1'b0, 16'h0000, 16'hCAFE, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    n_vec++;
    if ({val_a, val_d, val_s} !== 96'h00ABCDEE_0000CAFE_0000006C) begin
      n_err++;
      $display("FAIL freeze_release: got %h want %h", {val_a, val_d, val_s},
               96'h00ABCDEE_0000CAFE_0000006C);
    end else $display("ok   freeze_release: %h", {val_a, val_d, val_s});
  endtask

  task automatic test_berr;
    idle(6);
    bus_cycle(24'hFF8A00, 1'b1, 16'h9ABC, 16'h1111, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    n_vec++;
    if ({val_a, val_d, val_s} !== 96'h00FF8A00_00009ABC_000000BF) begin
      n_err++;
      $display("FAIL berr_only: got %h want %h", {val_a, val_d, val_s},
               96'h00FF8A00_00009ABC_000000BF);
    end else $display("ok   berr_only: %h", {val_a, val_d, val_s});
    idle(6);
    bus_cycle(24'h000002, 1'b0, 16'h3333, 16'h0001, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    n_vec++;
    if ({val_a, val_d, val_s} !== 96'h00000002_00000001_00000026) begin
      n_err++;
      $display("FAIL berr_and_dtack: got %h want %h", {val_a, val_d, val_s},
               96'h00000002_00000001_00000026);
    end else $display("ok   berr_and_dtack: %h", {val_a, val_d, val_s});
  endtask

  task automatic test_break;
    logic [95:0] exp_blocked;
    logic        exp_halt;
`ifdef DBG_BREAK_EN
    exp_blocked = 96'h00000420_00007777_000000BD;
    exp_halt    = 1'b1;
`else
    exp_blocked = 96'h00000800_00000800_000000BC;
    exp_halt    = 1'b0;
`endif
    idle(6);
    brk_addr = 24'h000420;
    brk_ena  = 1'b1;
    bus_cycle(24'h000420, 1'b1, 16'h7777, 16'h0000, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    n_vec++;
    if ({val_a, val_d, val_s} !== 96'h00000420_00007777_000000BD) begin
      n_err++;
      $display("FAIL brk_hit: got %h want %h", {val_a, val_d, val_s},
               96'h00000420_00007777_000000BD);
    end else $display("ok   brk_hit: %h", {val_a, val_d, val_s});
    n_vec++;
    if (halt !== exp_halt) begin
      n_err++;
      $display("FAIL brk_halt_set: got %b want %b", halt, exp_halt);
    end else $display("ok   brk_halt_set: %b", halt);
    idle(6);
    bus_cycle(24'h000800, 1'b1, 16'h0800, 16'h0000, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    n_vec++;
    if ({val_a, val_d, val_s} !== exp_blocked) begin
      n_err++;
      $display("FAIL brk_next: got %h want %h", {val_a, val_d, val_s}, exp_blocked);
    end else $display("ok   brk_next: %h", {val_a, val_d, val_s});
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    n_vec++;
    if (halt !== 1'b0) begin
      n_err++;
      $display("FAIL brk_resume: got %b want 0", halt);
    end else $display("ok   brk_resume: %b", halt);
`ifdef DBG_BREAK_EN
    bus_cycle(24'h000800, 1'b1, 16'h0800, 16'h0000, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    n_vec++;
    if ({val_a, val_d, val_s} !== 96'h00000800_00000800_000000BC) begin
      n_err++;
      $display("FAIL brk_after_resume: got %h want %h", {val_a, val_d, val_s},
               96'h00000800_00000800_000000BC);
    end else $display("ok   brk_after_resume: %h", {val_a, val_d, val_s});
`endif
    brk_ena = 1'b0;
  endtask

  task automatic test_reset_mid_wait;
    idle(6);
    cpu_addr  = 23'h000080;
    cpu_rw    = 1'b1;
    cpu_din   = 16'h2222;
    cpu_fc    = 3'd6;
    cpu_uds_n = 1'b0;
    cpu_lds_n = 1'b0;
    cpu_as_n  = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({val_a, val_d, val_s, halt} !== 97'h0) begin
      n_err++;
      $display("FAIL reset_mid_wait: got %h want 0", {val_a, val_d, val_s, halt});
    end else $display("ok   reset_mid_wait: %h", {val_a, val_d, val_s, halt});
    reset    = 1'b0;
    cpu_as_n = 1'b1;
    @(negedge clk);
    bus_cycle(24'h000100, 1'b1, 16'h2222, 16'h0000, 3'd6, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    n_vec++;
    if ({val_a, val_d, val_s} !== 96'h00000100_00002222_000000DD) begin
      n_err++;
      $display("FAIL post_reset_cycle: got %h want %h", {val_a, val_d, val_s},
               96'h00000100_00002222_000000DD);
    end else $display("ok   post_reset_cycle: %h", {val_a, val_d, val_s});
  endtask

  initial begin
    reset     = 1'b1;
    clken     = 1'b1;
    cpu_addr  = '0;
    cpu_din   = '0;
    cpu_dout  = '0;
    cpu_as_n  = 1'b1;
    cpu_uds_n = 1'b1;
    cpu_lds_n = 1'b1;
    cpu_rw    = 1'b1;
    cpu_fc    = '0;
    dtack_n   = 1'b1;
    berr_n    = 1'b1;
    freeze    = 1'b0;
    brk_addr  = '0;
    brk_ena   = 1'b0;
    resume    = 1'b0;
    @(negedge clk);
    test_reset();
    test_read();
    test_back_to_back();
    test_abort();
    test_clken();
    test_freeze();
    test_berr();
    test_break();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
